// File: rtl/knn_local_sp_fill_ctrl.sv
// Upstream controller for one partial-KNN local search-point buffer.
// Fills a single-port URAM from a valid/ready stream, then serves in-order
// random-access reads to the distance stage, sharing the one memory port.
// Optional build macro: KNN_SP_BOUNDS_CHECK_EN (out-of-range read detection).
module knn_local_sp_fill_ctrl #(
    parameter int DATA_WIDTH = 256,
    parameter int ADDR_WIDTH = 11,
    parameter int DEPTH      = 2048,
    parameter int RD_LAT     = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   num_words,
    output logic                  busy,
    output logic                  done,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  rd_req_valid,
    input  logic [ADDR_WIDTH-1:0] rd_req_addr,
    output logic                  rd_req_ready,
    output logic                  rd_rsp_valid,
    output logic [DATA_WIDTH-1:0] rd_rsp_data,
    output logic                  rd_oob,
    output logic [ADDR_WIDTH-1:0] mem_address0,
    output logic                  mem_ce0,
    output logic                  mem_we0,
    output logic [DATA_WIDTH-1:0] mem_d0,
    input  logic [DATA_WIDTH-1:0] mem_q0
);

    // state | meaning
    // IDLE  | no buffer content owned, waiting for start
    // FILL  | accepting stream beats, writing wr_ptr upward
    // SERVE | buffer filled, answering read requests
    typedef enum logic [1:0] {IDLE, FILL, SERVE} state_t;

    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] ONE_W   = (ADDR_WIDTH+1)'(1);

    state_t              state;
    logic [ADDR_WIDTH:0] wr_ptr;
    logic [ADDR_WIDTH:0] fill_len;
    logic [RD_LAT-1:0]   pipe_v;

    logic                wr_fire;
    logic                rd_fire;
    logic                req_oob;
    logic                pipe_empty;
    logic                start_ok;
    logic                last_beat;
    logic [ADDR_WIDTH:0] clamp_len;

    assign pipe_empty = ~|pipe_v;
    assign wr_fire    = reset & in_valid & in_ready;
    assign rd_fire    = reset & rd_req_valid & rd_req_ready;
    assign last_beat  = (wr_ptr == fill_len - ONE_W);
    assign clamp_len  = (num_words > DEPTH_W) ? DEPTH_W : num_words;
    // A request presented together with start in SERVE wins; start is dropped.
    assign start_ok   = start & ((state == IDLE) |
                                 ((state == SERVE) & pipe_empty & ~rd_req_valid));

`ifdef KNN_SP_BOUNDS_CHECK_EN
    logic [RD_LAT-1:0] oob_pipe;
    assign req_oob     = ({1'b0, rd_req_addr} >= fill_len);
    assign rd_rsp_data = oob_pipe[RD_LAT-1] ? '0 : mem_q0;
`else
    assign req_oob     = 1'b0;
    assign rd_oob      = 1'b0;
    assign rd_rsp_data = mem_q0;
`endif

    // Shared memory port: fill writes and serve reads never overlap by state.
    assign mem_ce0      = wr_fire | (rd_fire & ~req_oob);
    assign mem_we0      = wr_fire;
    assign mem_address0 = wr_fire ? wr_ptr[ADDR_WIDTH-1:0] : rd_req_addr;
    assign mem_d0       = in_data;
    assign rd_rsp_valid = pipe_v[RD_LAT-1];

    // Phase sequencing, fill pointer, read-latency pipe and registered handshakes.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            in_ready     <= 1'b0;
            rd_req_ready <= 1'b0;
            wr_ptr       <= '0;
            fill_len     <= '0;
            pipe_v       <= '0;
`ifdef KNN_SP_BOUNDS_CHECK_EN
            oob_pipe     <= '0;
            rd_oob       <= 1'b0;
`endif
        end else begin
            done      <= 1'b0;
            pipe_v[0] <= rd_fire;
            for (int i = 1; i < RD_LAT; i++) pipe_v[i] <= pipe_v[i-1];
`ifdef KNN_SP_BOUNDS_CHECK_EN
            oob_pipe[0] <= rd_fire & req_oob;
            for (int i = 1; i < RD_LAT; i++) oob_pipe[i] <= oob_pipe[i-1];
            if (pipe_v[RD_LAT-1] && oob_pipe[RD_LAT-1]) rd_oob <= 1'b1;
            if (start_ok) rd_oob <= 1'b0;
`endif
            if (wr_fire) wr_ptr <= wr_ptr + ONE_W;

            if (start_ok) begin
                fill_len <= clamp_len;
                wr_ptr   <= '0;
                if (clamp_len == '0) begin
                    state        <= SERVE;
                    done         <= 1'b1;
                    busy         <= 1'b0;
                    in_ready     <= 1'b0;
                    rd_req_ready <= 1'b1;
                end else begin
                    state        <= FILL;
                    busy         <= 1'b1;
                    in_ready     <= 1'b1;
                    rd_req_ready <= 1'b0;
                end
            end else if (state == FILL && wr_fire && last_beat) begin
                state        <= SERVE;
                done         <= 1'b1;
                busy         <= 1'b0;
                in_ready     <= 1'b0;
                rd_req_ready <= 1'b1;
            end
        end
    end

endmodule
